// File: rtl/br_pred_gshare.sv
// Fetch-stage branch predictor: tagged direct-mapped BTB plus a gshare PHT of
// 2-bit saturating counters, with a speculative global history register that
// is restored from the branch's fetch-time snapshot on a mispredict.
// Lookup is combinational from if_pc_i; training arrives from EX and takes
// effect at the clock edge, so a same-cycle lookup observes the old contents.
module br_pred_gshare #(
  parameter int BTB_ENTRIES = 64,
  parameter int PHT_ENTRIES = 256,
  parameter int HIST_LEN    = 8,
  parameter int TAG_W       = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_valid_i,
  input  logic [63:0]         if_pc_i,
  output logic [63:0]         btb_target_o,
  output logic                hit_o,
  output logic                pred_o,
  output logic [HIST_LEN-1:0] ghr_o,
  input  logic                ex_is_br_i,
  input  logic                ex_is_cond_i,
  input  logic                ex_is_taken_i,
  input  logic                ex_mispred_i,
  input  logic [63:0]         ex_pc_i,
  input  logic [63:0]         ex_br_target_i,
  input  logic [HIST_LEN-1:0] ex_ghr_i
);

  localparam int IB = $clog2(BTB_ENTRIES);
  localparam int IP = $clog2(PHT_ENTRIES);

  // Reject illegal configurations at elaboration time.
  if ((1 << IB) != BTB_ENTRIES) begin : g_bad_btb
    $error("br_pred_gshare: BTB_ENTRIES must be a power of 2");
  end
  if ((1 << IP) != PHT_ENTRIES) begin : g_bad_pht
    $error("br_pred_gshare: PHT_ENTRIES must be a power of 2");
  end
  if (HIST_LEN < 1 || HIST_LEN > IP) begin : g_bad_hist
    $error("br_pred_gshare: HIST_LEN must be in 1..log2(PHT_ENTRIES)");
  end
  if (IB + TAG_W + 2 > 64) begin : g_bad_tag
    $error("br_pred_gshare: IB+TAG_W+2 must not exceed 64");
  end

  // ---------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------
  logic [BTB_ENTRIES-1:0] btb_valid;
  logic [BTB_ENTRIES-1:0] btb_cond;
  logic [TAG_W-1:0]       btb_tag    [BTB_ENTRIES];
  logic [63:0]            btb_target [BTB_ENTRIES];
  logic [1:0]             pht        [PHT_ENTRIES];
  logic [HIST_LEN-1:0]    ghr;
  logic [HIST_LEN-1:0]    ghr_next;

  // ---------------------------------------------------------------------
  // Fetch-side lookup
  // ---------------------------------------------------------------------
  logic [IB-1:0]    if_idx;
  logic [TAG_W-1:0] if_tag;
  logic [IP-1:0]    if_ghr_ext;
  logic [IP-1:0]    if_pidx;
  logic             if_cond;

  assign if_idx = if_pc_i[IB+1:2];
  assign if_tag = if_pc_i[IB+TAG_W+1:IB+2];

  // Zero-extend the history to the PHT index width (works for HIST_LEN == IP).
  always_comb begin
    if_ghr_ext = '0;
    if_ghr_ext[HIST_LEN-1:0] = ghr;
  end

  assign if_pidx = if_pc_i[IP+1:2] ^ if_ghr_ext;
  assign if_cond = btb_cond[if_idx];

  assign hit_o        = btb_valid[if_idx] & (btb_tag[if_idx] == if_tag);
  assign pred_o       = hit_o & (~if_cond | pht[if_pidx][1]);
  assign btb_target_o = pred_o ? btb_target[if_idx] : (if_pc_i + 64'd4);
  assign ghr_o        = ghr;

  // ---------------------------------------------------------------------
  // Execute-side training decode
  // ---------------------------------------------------------------------
  logic [IB-1:0]    ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic [IP-1:0]    ex_ghr_ext;
  logic [IP-1:0]    ex_pidx;
  logic             btb_we;
  logic             pht_we;
  logic [1:0]       pht_cur;
  logic [1:0]       pht_upd;

  assign ex_idx = ex_pc_i[IB+1:2];
  assign ex_tag = ex_pc_i[IB+TAG_W+1:IB+2];

  // Training indexes with the history the branch was fetched under.
  always_comb begin
    ex_ghr_ext = '0;
    ex_ghr_ext[HIST_LEN-1:0] = ex_ghr_i;
  end

  assign ex_pidx = ex_pc_i[IP+1:2] ^ ex_ghr_ext;

  // Only taken branches allocate; not-taken ones leave the BTB untouched.
  assign btb_we = ex_is_br_i & ex_is_taken_i;
  assign pht_we = ex_is_br_i & ex_is_cond_i;

  assign pht_cur = pht[ex_pidx];

  // Saturating counter step for the trained entry.
  always_comb begin
    pht_upd = pht_cur;
    if (ex_is_taken_i) begin
      if (pht_cur != 2'b11) pht_upd = pht_cur + 2'd1;
    end else begin
      if (pht_cur != 2'b00) pht_upd = pht_cur - 2'd1;
    end
  end

  // PHT counters: each entry resets to weakly not-taken and updates when addressed.
  for (genvar gi = 0; gi < PHT_ENTRIES; gi++) begin : g_pht
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pht[gi] <= 2'b01;
      end else if (pht_we && (ex_pidx == IP'(gi))) begin
        pht[gi] <= pht_upd;
      end
    end
  end

  // BTB valid bits: cleared by reset, set on any taken-branch write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btb_valid <= '0;
    end else if (btb_we) begin
      btb_valid[ex_idx] <= 1'b1;
    end
  end

  // BTB condition flags: gated by valid, so no reset is needed.
  always_ff @(posedge clk) begin
    if (btb_we) begin
      btb_cond[ex_idx] <= ex_is_cond_i;
    end
  end

  // BTB payload (tag and target): overwritten unconditionally on alias.
  always_ff @(posedge clk) begin
    if (btb_we) begin
      btb_tag[ex_idx]    <= ex_tag;
      btb_target[ex_idx] <= ex_br_target_i;
    end
  end

  // ---------------------------------------------------------------------
  // Global history: recovery from EX beats the speculative fetch shift.
  // ---------------------------------------------------------------------
  logic [HIST_LEN-1:0] recov_shift;
  logic [HIST_LEN-1:0] fetch_shift;

  if (HIST_LEN == 1) begin : g_hist_one
    assign recov_shift = ex_is_taken_i;
    assign fetch_shift = pred_o;
  end else begin : g_hist_many
    assign recov_shift = {ex_ghr_i[HIST_LEN-2:0], ex_is_taken_i};
    assign fetch_shift = {ghr[HIST_LEN-2:0], pred_o};
  end

  // Next-history selection in priority order.
  always_comb begin
    ghr_next = ghr;
    if (ex_is_br_i && ex_mispred_i && ex_is_cond_i) begin
      ghr_next = recov_shift;
    end else if (ex_is_br_i && ex_mispred_i) begin
      ghr_next = ex_ghr_i;
    end else if (if_valid_i && hit_o && if_cond) begin
      ghr_next = fetch_shift;
    end
  end

  // History register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr <= '0;
    end else begin
      ghr <= ghr_next;
    end
  end

  // PC bits outside the index/tag fields do not participate.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc_i, ex_pc_i};

endmodule

// File: tb/tb_br_pred_gshare.sv
// Scoreboard bench for br_pred_gshare: the driver computes each cycle's
// expected lookup from a behavioural model and queues it; a monitor on the
// falling edge pops and compares against the DUT outputs.
module tb_br_pred_gshare;

  localparam int BTB = 64;
  localparam int PHT = 256;
  localparam int HL  = 8;
  localparam int TW  = 10;
  localparam int IB  = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_valid_i = 1'b0;
  logic [63:0]   if_pc_i = 64'h1000;
  logic [63:0]   btb_target_o;
  logic          hit_o;
  logic          pred_o;
  logic [HL-1:0] ghr_o;
  logic          ex_is_br_i = 1'b0;
  logic          ex_is_cond_i = 1'b0;
  logic          ex_is_taken_i = 1'b0;
  logic          ex_mispred_i = 1'b0;
  logic [63:0]   ex_pc_i = '0;
  logic [63:0]   ex_br_target_i = '0;
  logic [HL-1:0] ex_ghr_i = '0;

  br_pred_gshare #(.BTB_ENTRIES(BTB), .PHT_ENTRIES(PHT), .HIST_LEN(HL), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .if_valid_i(if_valid_i), .if_pc_i(if_pc_i),
    .btb_target_o(btb_target_o), .hit_o(hit_o), .pred_o(pred_o), .ghr_o(ghr_o),
    .ex_is_br_i(ex_is_br_i), .ex_is_cond_i(ex_is_cond_i), .ex_is_taken_i(ex_is_taken_i),
    .ex_mispred_i(ex_mispred_i), .ex_pc_i(ex_pc_i), .ex_br_target_i(ex_br_target_i),
    .ex_ghr_i(ex_ghr_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic        hit;
    logic        pred;
    logic [63:0] tgt;
    logic [7:0]  ghr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   txn = 0;

  // Reference model: whole-entry records addressed with plain arithmetic.
  bit              m_valid [BTB];
  longint unsigned m_tag   [BTB];
  longint unsigned m_tgt   [BTB];
  bit              m_cond  [BTB];
  int              m_pht   [PHT];
  int              m_ghr;

  function automatic int btb_slot(input longint unsigned pc);
    return int'((pc / 4) % BTB);
  endfunction

  function automatic longint unsigned btb_tagof(input longint unsigned pc);
    return (pc / (4 * BTB)) % (longint'(1) << TW);
  endfunction

  function automatic int pht_slot(input longint unsigned pc, input int hist);
    return int'(((pc / 4) % PHT) ^ longint'(hist));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < BTB; i++) m_valid[i] = 1'b0;
    for (int i = 0; i < PHT; i++) m_pht[i] = 1;
    m_ghr = 0;
  endtask

  // One cycle: drive at posedge+1, queue expected lookup, then advance the model.
  task automatic cyc(input bit r, input bit iv, input logic [63:0] ipc,
                     input bit br, input bit cnd, input bit tk, input bit mis,
                     input logic [63:0] epc, input logic [63:0] etgt, input logic [7:0] eg);
    exp_t e;
    int   s;
    int   p;
    bit   h;
    bit   pr;
    @(posedge clk);
    #1;
    rst = r;
    if_valid_i = iv; if_pc_i = ipc;
    ex_is_br_i = br; ex_is_cond_i = cnd; ex_is_taken_i = tk; ex_mispred_i = mis;
    ex_pc_i = epc; ex_br_target_i = etgt; ex_ghr_i = eg;
    if (r) model_reset();
    s  = btb_slot(ipc);
    h  = m_valid[s] && (m_tag[s] == btb_tagof(ipc));
    pr = h && (!m_cond[s] || m_pht[pht_slot(ipc, m_ghr)] >= 2);
    e.id   = txn;
    e.hit  = h;
    e.pred = pr;
    e.tgt  = pr ? m_tgt[s] : ipc + 64'd4;
    e.ghr  = 8'(m_ghr);
    exp_q.push_back(e);
    txn++;
    if (!r && br) begin
      if (mis && cnd)      m_ghr = ((int'(eg) * 2) + int'(tk)) % (1 << HL);
      else if (mis)        m_ghr = int'(eg);
      else if (iv && h && m_cond[s]) m_ghr = ((m_ghr * 2) + int'(pr)) % (1 << HL);
    end else if (!r && iv && h && m_cond[s]) begin
      m_ghr = ((m_ghr * 2) + int'(pr)) % (1 << HL);
    end
    if (!r && br && cnd) begin
      p = pht_slot(epc, int'(eg));
      if (tk) m_pht[p] = (m_pht[p] == 3) ? 3 : m_pht[p] + 1;
      else    m_pht[p] = (m_pht[p] == 0) ? 0 : m_pht[p] - 1;
    end
    if (!r && br && tk) begin
      s = btb_slot(epc);
      m_valid[s] = 1'b1;
      m_tag[s]   = btb_tagof(epc);
      m_tgt[s]   = etgt;
      m_cond[s]  = cnd;
    end
  endtask

  task automatic idle(input logic [63:0] ipc);
    cyc(0, 1, ipc, 0, 0, 0, 0, 64'h0, 64'h0, 8'h00);
  endtask

  // Monitor: compare queued expectations on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks += 4;
        if (hit_o !== e.hit) begin
          failures++;
          $display("FAIL hit txn=%0d got=%b want=%b", e.id, hit_o, e.hit);
        end
        if (pred_o !== e.pred) begin
          failures++;
          $display("FAIL pred txn=%0d got=%b want=%b", e.id, pred_o, e.pred);
        end
        if (btb_target_o !== e.tgt) begin
          failures++;
          $display("FAIL target txn=%0d got=%h want=%h", e.id, btb_target_o, e.tgt);
        end
        if (ghr_o !== e.ghr) begin
          failures++;
          $display("FAIL ghr txn=%0d got=%h want=%h", e.id, ghr_o, e.ghr);
        end
        $display("txn %0d hit=%b pred=%b tgt=%h ghr=%h", e.id, hit_o, pred_o, btb_target_o, ghr_o);
      end
    end
  end

  // Stimulus: directed scenarios, then randomized traffic with a mid-run reset.
  initial begin
    logic [63:0] pool [8];
    logic [63:0] a;
    logic [63:0] b;
    int          wait_cycles;
    pool[0] = 64'h1000; pool[1] = 64'h1040; pool[2] = 64'h1100; pool[3] = 64'h3000;
    pool[4] = 64'h2004; pool[5] = 64'h1044; pool[6] = 64'h5100; pool[7] = 64'h3100;
    model_reset();

    // Reset state with a lookup of 0x1000.
    cyc(1, 1, 64'h1000, 0, 0, 0, 0, 64'h0, 64'h0, 8'h00);
    cyc(1, 1, 64'h1000, 0, 0, 0, 0, 64'h0, 64'h0, 8'h00);
    idle(64'h1000);

    // Unconditional taken branch, then hit next cycle.
    cyc(0, 0, 64'h1000, 1, 0, 1, 0, 64'h1000, 64'h2000, 8'h00);
    idle(64'h1000);

    // Conditional 0x1040 trained up, then down, looked up with GHR=0.
    cyc(0, 0, 64'h0, 1, 1, 1, 0, 64'h1040, 64'h5000, 8'h00);
    cyc(0, 0, 64'h0, 1, 1, 1, 0, 64'h1040, 64'h5000, 8'h00);
    cyc(0, 0, 64'h1040, 0, 0, 0, 0, 64'h0, 64'h0, 8'h00);
    repeat (3) cyc(0, 0, 64'h0, 1, 1, 0, 0, 64'h1040, 64'h5000, 8'h00);
    cyc(0, 0, 64'h1040, 0, 0, 0, 0, 64'h0, 64'h0, 8'h00);

    // GHR=0x05 via uncond recovery, train 0x1040 under that history, fetch shift.
    cyc(0, 0, 64'h0, 1, 0, 1, 1, 64'h1000, 64'h2000, 8'h05);
    cyc(0, 0, 64'h0, 1, 1, 1, 0, 64'h1040, 64'h5000, 8'h05);
    cyc(0, 0, 64'h0, 1, 1, 1, 0, 64'h1040, 64'h5000, 8'h05);
    cyc(0, 0, 64'h0, 1, 1, 1, 0, 64'h1040, 64'h5000, 8'h05);
    cyc(0, 1, 64'h1040, 0, 0, 0, 0, 64'h0, 64'h0, 8'h00);
    idle(64'h0);
    // Recovery beats a same-cycle fetch shift.
    cyc(0, 0, 64'h0, 1, 0, 1, 1, 64'h1000, 64'h2000, 8'h05);
    cyc(0, 1, 64'h1040, 1, 1, 0, 1, 64'h1080, 64'h0, 8'h03);
    idle(64'h0);

    // Same-cycle write and lookup of 0x3000.
    cyc(0, 1, 64'h3000, 1, 0, 1, 0, 64'h3000, 64'h3500, 8'h00);
    idle(64'h3000);

    // Aliasing entries: second write replaces the first.
    cyc(0, 0, 64'h0, 1, 0, 1, 0, 64'h1000, 64'h2000, 8'h00);
    cyc(0, 0, 64'h0, 1, 0, 1, 0, 64'h1000 + 4 * BTB, 64'h7000, 8'h00);
    idle(64'h1000);
    idle(64'h1000 + 4 * BTB);

    // Mispredict flag alone with ex_is_br_i low is ignored.
    cyc(0, 1, 64'h1040, 0, 1, 1, 1, 64'h1040, 64'h0, 8'hAA);
    idle(64'h1040);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      a = pool[$urandom_range(0, 7)];
      b = pool[$urandom_range(0, 7)];
      if ($urandom_range(0, 9) == 0) a = {$urandom, $urandom};
      cyc((i == 700) ? 1'b1 : 1'b0,
          1'($urandom_range(0, 1)), a,
          ($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
          b, {$urandom, $urandom},
          ($urandom_range(0, 1) == 0) ? 8'(m_ghr) : 8'($urandom));
    end
    idle(64'h1000);

    // Drain the scoreboard with a bounded wait.
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
